// File: rtl/store_buffer_pkg.sv
// Shared types for the store buffer: store width encoding and the buffered store payload.
package store_buffer_pkg;

    typedef enum logic [1:0] {
        BYTE      = 2'd0,
        HALF_WORD = 2'd1,
        WORD      = 2'd2
    } store_width_t;

    typedef struct packed {
        logic [31:0]  address;
        logic [31:0]  data;
        store_width_t store_width;
    } store_buffer_entry_t;

endpackage

// File: rtl/store_buffer_if.sv
// Store-unit / controller / load-unit side bundle of the store buffer.
interface store_buffer_if;
    import store_buffer_pkg::*;

    logic                push_i;
    store_buffer_entry_t push_entry_i;
    logic                full_o;
    logic                empty_o;
    logic                request_o;
    store_buffer_entry_t buffer_entry_o;
    logic                valid_i;
    logic [31:0]         load_address_i;
    logic [1:0]          load_width_i;
    logic                forward_hit_o;
    logic [31:0]         forward_data_o;
    logic                conflict_o;

    // Environment side: store unit, cache controller and load unit.
    modport master (
        output push_i, push_entry_i, valid_i, load_address_i, load_width_i,
        input  full_o, empty_o, request_o, buffer_entry_o,
               forward_hit_o, forward_data_o, conflict_o
    );

    // Buffer side.
    modport slave (
        input  push_i, push_entry_i, valid_i, load_address_i, load_width_i,
        output full_o, empty_o, request_o, buffer_entry_o,
               forward_hit_o, forward_data_o, conflict_o
    );

endinterface

// File: rtl/store_buffer.sv
// Circular store FIFO draining to the D-cache store controller, with
// combinational store-to-load forwarding and conflict detection.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         halt_i,
    store_buffer_if.slave sb
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    store_buffer_entry_t     entries_q [DEPTH];
    logic [DEPTH-1:0]        valid_q;
    logic [PTR_W-1:0]        head_q;
    logic [PTR_W-1:0]        tail_q;
    logic [CNT_W-1:0]        count_q;

    logic                    full;
    logic                    empty;
    logic                    push_en;
    logic                    pop_en;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == CNT_W'(0));
    assign push_en = sb.push_i  && !full  && !halt_i;
    assign pop_en  = sb.valid_i && !empty && !halt_i;

    assign sb.full_o         = full;
    assign sb.empty_o        = empty;
    assign sb.request_o      = !empty;
    assign sb.buffer_entry_o = entries_q[head_q];

    // Pointer, count and valid-bit bookkeeping.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            if (push_en) begin
                tail_q          <= tail_q + PTR_W'(1);
                valid_q[tail_q] <= 1'b1;
            end
            if (pop_en) begin
                head_q          <= head_q + PTR_W'(1);
                valid_q[head_q] <= 1'b0;
            end
            case ({push_en, pop_en})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Payload storage needs no reset; valid bits qualify it.
    always_ff @(posedge clk_i) begin
        if (push_en) begin
            entries_q[tail_q] <= sb.push_entry_i;
        end
    end

    logic             match;
    logic             hit;
    logic [PTR_W-1:0] sel;
    logic [PTR_W-1:0] idx;

    // Walk oldest to youngest so the last word match seen is the youngest.
    always_comb begin
        match = 1'b0;
        sel   = '0;
        idx   = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = head_q + PTR_W'(i);
            if (valid_q[idx] &&
                (entries_q[idx].address[31:2] == sb.load_address_i[31:2])) begin
                match = 1'b1;
                sel   = idx;
            end
        end
        hit = match &&
              (entries_q[sel].address == sb.load_address_i) &&
              (2'(entries_q[sel].store_width) == sb.load_width_i);
    end

    assign sb.forward_hit_o  = hit;
    assign sb.conflict_o     = match && !hit;
    assign sb.forward_data_o = entries_q[sel].data;

endmodule
